// File: rtl/mesh_term_fifo_bank.sv
// mesh_term_fifo_bank: bank of CHANNELS independent first-word-fall-through
// terminal FIFOs feeding the mesh edge terminals.
// Each channel has a selectable overflow policy, an almost-full flag,
// broadcast-head detection, a saturating drop counter and a synchronous flush.
// Ports:
//   clk, reset (async, active-low)
//   flush/push/pop [CHANNELS]   per-channel clear / write / read strobes
//   data_in  [CHANNELS*pckg_sz] per-channel write data, channel i at [i*pckg_sz +: pckg_sz]
//   pndng/full/almost_full/head_bdcst [CHANNELS]  registered status
//   data_out [CHANNELS*pckg_sz] registered head packet of each channel (0 when empty)
//   drop_cnt [CHANNELS*CNT_W]   saturating lost-packet count per channel
module mesh_term_fifo_bank #(
   parameter int unsigned          CHANNELS   = 16,
   parameter int unsigned          pckg_sz    = 40,
   parameter int unsigned          fifo_depth = 4,
   parameter logic [pckg_sz-19:0]  bdcst      = {(pckg_sz-18){1'b1}},
   parameter int unsigned          OVF_MODE   = 0,
   parameter int unsigned          AF_LVL     = fifo_depth-1,
   parameter int unsigned          CNT_W      = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [CHANNELS-1:0]           flush,
   input  logic [CHANNELS-1:0]           push,
   input  logic [CHANNELS*pckg_sz-1:0]   data_in,
   input  logic [CHANNELS-1:0]           pop,
   output logic [CHANNELS-1:0]           pndng,
   output logic [CHANNELS*pckg_sz-1:0]   data_out,
   output logic [CHANNELS-1:0]           full,
   output logic [CHANNELS-1:0]           almost_full,
   output logic [CHANNELS-1:0]           head_bdcst,
   output logic [CHANNELS*CNT_W-1:0]     drop_cnt
);

   localparam int unsigned PTR_W = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
   localparam int unsigned OCC_W = $clog2(fifo_depth + 1);

   // Circular pointer advance; explicit wrap so any depth works.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(fifo_depth - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
      logic [pckg_sz-1:0] mem [fifo_depth];
      logic [PTR_W-1:0]   rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
      logic [OCC_W-1:0]   occ, occ_n;
      logic [CNT_W-1:0]   drops, drops_n;
      logic [pckg_sz-1:0] wdata, head_n;
      logic               do_pop, accept, drop_ev, wr_en, rd_adv;
      logic               pndng_r, full_r, af_r, hb_r;
      logic [pckg_sz-1:0] dout_r;

      assign wdata = data_in[i*pckg_sz +: pckg_sz];

      // Next-state: flush wins, pop only when non-empty, full+pop frees a slot.
      always_comb begin
         do_pop   = 1'b0;
         accept   = 1'b0;
         drop_ev  = 1'b0;
         wr_en    = 1'b0;
         rd_adv   = 1'b0;
         rd_ptr_n = rd_ptr;
         wr_ptr_n = wr_ptr;
         occ_n    = occ;
         drops_n  = drops;
         head_n   = '0;

         do_pop  = pop[i] && (occ != '0) && !flush[i];
         accept  = push[i] && !flush[i] && ((occ != OCC_W'(fifo_depth)) || do_pop);
         drop_ev = push[i] && !flush[i] && !accept;
         wr_en   = accept || (drop_ev && (OVF_MODE != 0));
         rd_adv  = do_pop || (drop_ev && (OVF_MODE != 0));

         if (flush[i]) begin
            rd_ptr_n = '0;
            wr_ptr_n = '0;
            occ_n    = '0;
         end else begin
            if (rd_adv) rd_ptr_n = ptr_inc(rd_ptr);
            if (wr_en)  wr_ptr_n = ptr_inc(wr_ptr);
            if (accept && !do_pop)      occ_n = occ + OCC_W'(1);
            else if (do_pop && !accept) occ_n = occ - OCC_W'(1);
         end

         if (drop_ev && (drops != '1)) drops_n = drops + CNT_W'(1);

         // Head after this edge; a write landing at the new head bypasses the RAM.
         if (occ_n != '0) begin
            if (wr_en && (wr_ptr == rd_ptr_n)) head_n = wdata;
            else                               head_n = mem[rd_ptr_n];
         end
      end

      // Data RAM carries no reset; unreachable contents are masked by occupancy.
      always_ff @(posedge clk) begin
         if (wr_en) mem[wr_ptr] <= wdata;
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ     <= '0;
            drops   <= '0;
            pndng_r <= 1'b0;
            full_r  <= 1'b0;
            af_r    <= 1'b0;
            hb_r    <= 1'b0;
            dout_r  <= '0;
         end else begin
            rd_ptr  <= rd_ptr_n;
            wr_ptr  <= wr_ptr_n;
            occ     <= occ_n;
            drops   <= drops_n;
            pndng_r <= (occ_n != '0);
            full_r  <= (occ_n == OCC_W'(fifo_depth));
            af_r    <= (occ_n >= OCC_W'(AF_LVL));
            hb_r    <= (occ_n != '0) && (head_n[pckg_sz-9 -: pckg_sz-18] == bdcst);
            dout_r  <= head_n;
         end
      end

      assign pndng[i]                      = pndng_r;
      assign full[i]                       = full_r;
      assign almost_full[i]                = af_r;
      assign head_bdcst[i]                 = hb_r;
      assign data_out[i*pckg_sz +: pckg_sz] = dout_r;
      assign drop_cnt[i*CNT_W +: CNT_W]    = drops;
   end

endmodule

// File: tb/tb_mesh_term_fifo_bank.sv
// Bench for mesh_term_fifo_bank: two instances (drop policy depth 4 / 8-bit
// counters, and overwrite policy depth 3 / 2-bit counters) share one stimulus
// stream and are compared each cycle against per-channel packet queues.
module tb_mesh_term_fifo_bank;

   localparam int CH = 16;
   localparam int PW = 40;

   logic            clk = 1'b0;
   logic            reset;
   logic [CH-1:0]   flush, push, pop;
   logic [CH*PW-1:0] data_in;

   logic [CH-1:0]    pnd0, full0, af0, hb0, pnd1, full1, af1, hb1;
   logic [CH*PW-1:0] do0, do1;
   logic [CH*8-1:0]  dc0;
   logic [CH*2-1:0]  dc1;

   int checks = 0;
   int errors = 0;

   // Reference: queue contents and drop totals per (instance, channel).
   logic [PW-1:0] mq [32][$];
   int            mdrop [32];
   int            dep  [2] = '{4, 3};
   int            ovw  [2] = '{0, 1};
   int            aflv [2] = '{3, 2};
   int            dmax [2] = '{255, 3};

   mesh_term_fifo_bank #(.CHANNELS(CH), .pckg_sz(PW), .fifo_depth(4), .OVF_MODE(0), .CNT_W(8)) dut0 (
      .clk(clk), .reset(reset), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
      .pndng(pnd0), .data_out(do0), .full(full0), .almost_full(af0), .head_bdcst(hb0), .drop_cnt(dc0));

   mesh_term_fifo_bank #(.CHANNELS(CH), .pckg_sz(PW), .fifo_depth(3), .OVF_MODE(1), .CNT_W(2)) dut1 (
      .clk(clk), .reset(reset), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
      .pndng(pnd1), .data_out(do1), .full(full1), .almost_full(af1), .head_bdcst(hb1), .drop_cnt(dc1));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [CH*PW-1:0] obs, input logic [CH*PW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [CH*PW-1:0] pk(input int ch, input logic [PW-1:0] v);
      logic [CH*PW-1:0] r;
      r = '0;
      r[ch*PW +: PW] = v;
      return r;
   endfunction

   function automatic logic [CH-1:0] bitv(input int ch);
      return CH'(1) << ch;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 32; k++) begin
         mq[k].delete();
         mdrop[k] = 0;
      end
   endtask

   task automatic model_apply(input logic [CH-1:0] pu, po, fl, input logic [CH*PW-1:0] din);
      for (int d = 0; d < 2; d++) begin
         for (int c = 0; c < CH; c++) begin
            int  k;
            bit  pn;
            k = d*CH + c;
            if (fl[c]) begin
               mq[k].delete();
            end else begin
               pn = po[c] && (mq[k].size() > 0);
               if (pu[c]) begin
                  if (mq[k].size() < dep[d] || pn) begin
                     if (pn) void'(mq[k].pop_front());
                     mq[k].push_back(din[c*PW +: PW]);
                  end else begin
                     if (ovw[d] != 0) begin
                        void'(mq[k].pop_front());
                        mq[k].push_back(din[c*PW +: PW]);
                     end
                     if (mdrop[k] < dmax[d]) mdrop[k]++;
                  end
               end else if (pn) begin
                  void'(mq[k].pop_front());
               end
            end
         end
      end
   endtask

   task automatic check_all();
      for (int d = 0; d < 2; d++) begin
         logic [CH-1:0]    e_pnd, e_full, e_af, e_hb;
         logic [CH*PW-1:0] e_do;
         logic [CH*8-1:0]  e_dc;
         for (int c = 0; c < CH; c++) begin
            int            k, sz;
            logic [PW-1:0] hd;
            k  = d*CH + c;
            sz = mq[k].size();
            hd = (sz > 0) ? mq[k][0] : '0;
            e_pnd[c]          = (sz > 0);
            e_full[c]         = (sz == dep[d]);
            e_af[c]           = (sz >= aflv[d]);
            e_hb[c]           = (sz > 0) && (hd[31:10] == 22'h3FFFFF);
            e_do[c*PW +: PW]  = hd;
            e_dc[c*8 +: 8]    = 8'(mdrop[k]);
         end
         if (d == 0) begin
            chk("d0_pndng", pnd0, e_pnd);
            chk("d0_full", full0, e_full);
            chk("d0_almost_full", af0, e_af);
            chk("d0_head_bdcst", hb0, e_hb);
            chk("d0_data_out", do0, e_do);
            chk("d0_drop_cnt", dc0, e_dc);
         end else begin
            logic [CH*2-1:0] e_dc2;
            for (int c = 0; c < CH; c++) e_dc2[c*2 +: 2] = e_dc[c*8 +: 2];
            chk("d1_pndng", pnd1, e_pnd);
            chk("d1_full", full1, e_full);
            chk("d1_almost_full", af1, e_af);
            chk("d1_head_bdcst", hb1, e_hb);
            chk("d1_data_out", do1, e_do);
            chk("d1_drop_cnt", dc1, e_dc2);
         end
      end
   endtask

   // One clock: drive at the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic [CH-1:0] pu, po, fl, input logic [CH*PW-1:0] din);
      @(negedge clk);
      push = pu; pop = po; flush = fl; data_in = din;
      model_apply(pu, po, fl, din);
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      reset = 1'b0; flush = '0; push = '0; pop = '0; data_in = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
      reset = 1'b1;

      // Reset mid-stream: three packets on ch0, then a short async reset pulse.
      for (int j = 0; j < 3; j++) step(bitv(0), '0, '0, pk(0, 40'hA1 + 40'(j)));
      @(negedge clk);
      push = '0; pop = '0; flush = '0;
      #1 reset = 1'b0;
      #1;
      chk("rst_async_pndng0", pnd0, '0);
      chk("rst_async_dout0", do0, '0);
      chk("rst_async_drop0", dc0, '0);
      chk("rst_async_pndng1", pnd1, '0);
      model_clear();
      #1 reset = 1'b1;
      step('0, bitv(0), '0, '0);
      chk("rst_pop_after", pnd0[0], 1'b0);

      // Fill and overflow ch3 with 1..5.
      for (int v = 1; v <= 5; v++) begin
         step(bitv(3), '0, '0, pk(3, 40'(v)));
         if (v == 3) chk("af_after_3rd", af0[3], 1'b1);
         if (v == 3) chk("full_not_at_3rd", full0[3], 1'b0);
         if (v == 4) chk("full_after_4th", full0[3], 1'b1);
      end
      chk("d0_drop_ch3", dc0[3*8 +: 8], 8'd1);
      chk("d1_drop_ch3", dc1[3*2 +: 2], 2'd2);
      chk("d1_head_ch3_ovw", do1[3*PW +: PW], 40'h3);

      // Full with push and pop together: no drop, oldest leaves.
      step(bitv(3), bitv(3), '0, pk(3, 40'h6));
      chk("fpp_d0_head", do0[3*PW +: PW], 40'h2);
      chk("fpp_d0_full", full0[3], 1'b1);
      chk("fpp_d0_drop", dc0[3*8 +: 8], 8'd1);
      chk("fpp_d1_head", do1[3*PW +: PW], 40'h4);
      for (int j = 0; j < 5; j++) step('0, bitv(3), '0, '0);
      chk("drain_empty", pnd0[3], 1'b0);

      // Broadcast head detection.
      step(bitv(5), '0, '0, pk(5, 40'h00_FFFF_FC00));
      chk("bdcst_d0", hb0[5], 1'b1);
      chk("bdcst_d1", hb1[5], 1'b1);
      step('0, bitv(5), '0, '0);
      chk("bdcst_gone", hb0[5], 1'b0);

      // Interleaved pushes/pops across the pointer wrap, plus pops on empty.
      for (int j = 0; j < 7; j++) step(bitv(5), (j % 2 == 1) ? bitv(5) : '0, '0, pk(5, 40'h10 + 40'(j)));
      for (int j = 0; j < 6; j++) step('0, bitv(5), '0, '0);

      // Counter saturation, then flush racing a push.
      for (int j = 0; j < 8; j++) step(bitv(1), '0, '0, pk(1, 40'h20 + 40'(j)));
      chk("sat_d1", dc1[1*2 +: 2], 2'd3);
      chk("sat_d0", dc0[1*8 +: 8], 8'd4);
      step(bitv(1) | bitv(2), '0, bitv(1), pk(1, 40'h77) | pk(2, 40'h88));
      chk("flush_pnd_d0", pnd0[1], 1'b0);
      chk("flush_pnd_d1", pnd1[1], 1'b0);
      chk("flush_keep_drop", dc1[1*2 +: 2], 2'd3);
      chk("flush_other_ch", do0[2*PW +: PW], 40'h88);

      // Randomized traffic, alternating fill-biased and drain-biased phases.
      for (int n = 0; n < 400; n++) begin
         logic [CH-1:0]    pu, po, fl;
         logic [CH*PW-1:0] din;
         if ((n / 50) % 2 == 0) begin
            pu = CH'($urandom);
            po = CH'($urandom) & CH'($urandom);
         end else begin
            pu = CH'($urandom) & CH'($urandom);
            po = CH'($urandom);
         end
         fl = CH'($urandom) & CH'($urandom) & CH'($urandom) & CH'($urandom);
         for (int c = 0; c < CH; c++) begin
            din[c*PW +: PW] = {8'($urandom), 32'($urandom)};
            if ($urandom_range(3) == 0) din[c*PW + 10 +: 22] = '1;
         end
         step(pu, po, fl, din);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
